pipemdu: RTL and testbench
==========================

# pipemdu

Iterative multiply/divide unit in the execute stage of the 5-stage pipeline. It consumes the E-stage operand and control outputs of the decode/execute pipeline register: the rs and rt operands plus a start strobe and opcode. It computes MIPS mult/multu/div/divu into private HI/LO registers over a fixed multi-cycle latency. While busy it raises a stall request that holds the fetch, decode and execute stages.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits; iteration count equals WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- estart  in  1  E-stage issues an MDU op this cycle.
- eop  in  2  opcode:
  - 00 multu
  - 01 mult
  - 10 divu
  - 11 div
- ea  in  WIDTH  rs operand (multiplicand/dividend).
- eb  in  WIDTH  rt operand (multiplier/divisor).
- ecancel  in  1  pipeline flush; aborts an in-flight op.
- ebusy  out  1  stall request, registered.
- edone  out  1  one-cycle pulse, registered; HI/LO valid.
- hi  out  WIDTH  HI register (product high / remainder).
- lo  out  WIDTH  LO register (product low / quotient).

## Operation
- State machine: IDLE, RUN, FIX.
- IDLE, estart=1, ecancel=0:
  - latch eop.
  - For signed ops, latch |ea| and |eb| and record result signs; otherwise latch the raw operands.
  - Clear the WIDTH-bit iteration counter and the 2·WIDTH accumulator.
  - Go to RUN.
- RUN: one iteration per cycle.
  - Multiply: shift-add radix-2.
  - Divide: restoring radix-2.
  - After WIDTH iterations (counter reaches WIDTH-1), go to FIX.
- FIX:
  - Apply sign correction. Product is negated if operand signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign.
  - Write hi/lo, set edone, return to IDLE.
- Arithmetic rules:
  - mult/multu: {hi,lo} = full 2·WIDTH-bit product.
  - div/divu: lo = quotient, hi = remainder, truncating toward zero.
  - Divide by zero (any signedness): lo = all ones, hi = ea as issued.
  - Signed overflow (-2^(WIDTH-1) / -1): lo = 0x80000000, hi = 0.
- hi/lo change only in the FIX→IDLE transition; they hold otherwise, including across cancel.
- estart while in RUN or FIX is ignored; the issuing stage is stalled by ebusy.
- ecancel in RUN/FIX: next edge goes to IDLE; ebusy=0, no edone, hi/lo unchanged.
- estart and ecancel together in IDLE: cancel wins, op not started.
- Reset: state IDLE, counter 0, ebusy=0, edone=0, hi=0, lo=0, accumulator 0. Reset mid-op discards the op and produces no edone.

## Timing
- Start sampled at edge E0; ebusy=1 from E0.
- Iterations occur at E1..E32; FIX entered at E32.
- At E33: hi/lo written, edone=1 for exactly one cycle, ebusy=0.
- Latency is 33 edges (WIDTH+1), fixed for all ops and operands, including divide by zero.
- A new estart is accepted at any edge from E34 (state IDLE), including while edone=1. Back-to-back ops have a 34-cycle issue interval.
- ebusy and edone are never high in the same cycle.

## Configuration
- MDU_SIGNED_EN defined:
  - mult and div perform signed operations as above.
  - The sign-latch and FIX correction logic is present.
- MDU_SIGNED_EN undefined:
  - eop[0] is ignored; mult behaves as multu and div as divu.
  - Sign logic is removed, but FIX still occupies one cycle, so latency stays WIDTH+1.
  - Divide-by-zero result is unchanged.

## Test plan
- multu ea=0xFFFFFFFF, eb=0xFFFFFFFF -> at E33 hi=0xFFFFFFFE, lo=0x00000001; edone for 1 cycle; ebusy high E0..E33.
- mult ea=0xFFFFFFFD (-3), eb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Without MDU_SIGNED_EN -> hi=0x00000006, lo=0xFFFFFFEB.
- div ea=0xFFFFFFF9 (-7), eb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu ea=100, eb=0 -> lo=0xFFFFFFFF, hi=100, still at E33.
- div ea=0x80000000, eb=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start divu 100/7 then ecancel at E10 -> ebusy=0 at E11, no edone, hi/lo keep prior values. A new estart at E12 completes at E12+33 with lo=14, hi=2.
- Assert reset at E20 of an op -> all outputs 0 after next edge, no edone. estart held high during busy is ignored; its re-issue at E34 is accepted.

Source files
------------

// File: rtl/pipemdu.sv
// pipemdu: iterative MIPS mult/multu/div/divu unit, HI/LO, WIDTH+1 latency.
// Define MDU_SIGNED_EN to enable signed mult/div; otherwise eop[0] is ignored.
module pipemdu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             estart,
  input  logic [1:0]       eop,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic             ecancel,
  output logic             ebusy,
  output logic             edone,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH - 1;

  state_t             state, nstate;
  logic [WIDTH-1:0]   cnt, ra, rb;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic               isdiv, negq, negr, dz;
  logic               sgn;
  logic [WIDTH-1:0]   absa, absb;
  logic [WIDTH:0]     msum, dsh, ddif;
  logic               ge;
  logic [WIDTH-1:0]   rem, qfix, rfix;

`ifdef MDU_SIGNED_EN
  assign sgn  = eop[0];
  assign absa = (sgn && ea[WIDTH-1]) ? -ea : ea;
  assign absb = (sgn && eb[WIDTH-1]) ? -eb : eb;
`else
  // signed opcodes fold onto their unsigned forms
  assign sgn  = eop[0] & 1'b0;
  assign absa = ea;
  assign absb = eb;
`endif

  always_comb begin
    msum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + {1'b0, (rb[0] ? ra : '0)};
    dsh    = {acc[2*WIDTH-1:WIDTH], ra[WIDTH-1]};
    ddif   = dsh - {1'b0, rb};
    ge     = dsh >= {1'b0, rb};
    rem    = ge ? ddif[WIDTH-1:0] : dsh[WIDTH-1:0];
    acc_nx = isdiv ? {rem, acc[WIDTH-2:0], ge}
                   : {msum, acc[WIDTH-1:1]};
    prod   = negq ? -acc : acc;
    qfix   = negq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    if (dz)
      qfix = '1;
    rfix   = negr ? -acc[2*WIDTH-1:WIDTH]
                  : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (estart && !ecancel) nstate = RUN;
      RUN: begin
        if (ecancel)          nstate = IDLE;
        else if (cnt == LAST) nstate = FIX;
      end
      FIX:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ra    <= '0;
      rb    <= '0;
      isdiv <= 1'b0;
      negq  <= 1'b0;
      negr  <= 1'b0;
      dz    <= 1'b0;
      ebusy <= 1'b0;
      edone <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= nstate;
      ebusy <= nstate != IDLE;
      edone <= state == FIX && !ecancel;
      unique case (state)
        IDLE: if (estart && !ecancel) begin
          isdiv <= eop[1];
          ra    <= absa;
          rb    <= absb;
          negq  <= sgn & (ea[WIDTH-1] ^ eb[WIDTH-1]);
          negr  <= sgn & ea[WIDTH-1];
          dz    <= eb == '0;
          cnt   <= '0;
          acc   <= '0;
        end
        RUN: if (!ecancel) begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          // dividend streams out MSB-first, multiplier LSB-first
          if (isdiv) ra <= ra << 1;
          else       rb <= rb >> 1;
        end
        FIX: if (!ecancel) begin
          if (isdiv) {hi, lo} <= {rfix, qfix};
          else       {hi, lo} <= prod;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipemdu.sv
// tb_pipemdu: table vectors, random ops and cancel/reset/hold sequences
// checked through an expected-result queue.
module tb_pipemdu;

  logic        clock = 1'b0;
  logic        reset, estart, ecancel;
  logic [1:0]  eop;
  logic [31:0] ea, eb, hi, lo;
  logic        ebusy, edone;

  pipemdu #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .estart(estart),
    .eop(eop), .ea(ea), .eb(eb), .ecancel(ecancel),
    .ebusy(ebusy), .edone(edone), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, h, l;
  } vec_t;

  typedef struct {
    logic [31:0] h, l;
  } exp_t;

  vec_t        tab[10];
  exp_t        sq[$];
  int          ncmp = 0;
  int          nbad = 0;
  logic [31:0] last_h = '0;
  logic [31:0] last_l = '0;

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(logic [1:0] op,
                                         logic [31:0] a,
                                         logic [31:0] b);
    logic               s;
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, r;
`ifdef MDU_SIGNED_EN
    s = op[0];
`else
    s = 1'b0;
`endif
    if (!op[1]) begin
      if (s) begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
      end
      return {32'b0, a} * {32'b0, b};
    end
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF)
        return {32'h0, 32'h80000000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(logic [1:0] op, logic [31:0] a,
                       logic [31:0] b, logic [31:0] h,
                       logic [31:0] l, bit hold);
    exp_t e;
    e.h = h;
    e.l = l;
    sq.push_back(e);
    estart = 1'b1;
    eop    = op;
    ea     = a;
    eb     = b;
    tick();
    if (!hold) estart = 1'b0;
    check("busy_e0", {63'b0, ebusy}, 64'd1);
  endtask

  task automatic wait_done();
    int   n = 0;
    bit   drop = 0;
    exp_t e;
    while (n < 40) begin
      tick();
      n++;
      if (edone) break;
      if (!ebusy) drop = 1;
    end
    check("latency", 64'(n), 64'd33);
    check("busy_held", {63'b0, drop}, 64'd0);
    check("busy_at_done", {63'b0, ebusy}, 64'd0);
    if (sq.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sq.pop_front();
      check("hi", {32'b0, hi}, {32'b0, e.h});
      check("lo", {32'b0, lo}, {32'b0, e.l});
      last_h = e.h;
      last_l = e.l;
    end
  endtask

  initial begin
    logic [63:0] m;
    bit          seen;
    tab[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001};
    tab[3] = '{2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF};
    tab[7] = '{2'b11, 32'hFFFFFF00, 32'd0,
               32'hFFFFFF00, 32'hFFFFFFFF};
    tab[8] = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14};
    tab[9] = '{2'b00, 32'h10000, 32'h10000, 32'd1, 32'd0};
`ifdef MDU_SIGNED_EN
    tab[1] = '{2'b01, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB};
    tab[2] = '{2'b11, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD};
    tab[4] = '{2'b11, 32'h80000000, 32'hFFFFFFFF,
               32'h0, 32'h80000000};
    tab[5] = '{2'b01, 32'hFFFFFFFB, 32'hFFFFFFFA,
               32'h0, 32'h1E};
    tab[6] = '{2'b11, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD};
`else
    tab[1] = '{2'b01, 32'hFFFFFFFD, 32'd7,
               32'h6, 32'hFFFFFFEB};
    tab[2] = '{2'b11, 32'hFFFFFFF9, 32'd2,
               32'd1, 32'h7FFFFFFC};
    tab[4] = '{2'b11, 32'h80000000, 32'hFFFFFFFF,
               32'h80000000, 32'h0};
    tab[5] = '{2'b01, 32'hFFFFFFFB, 32'hFFFFFFFA,
               32'hFFFFFFF5, 32'h1E};
    tab[6] = '{2'b11, 32'd7, 32'hFFFFFFFE,
               32'd7, 32'd0};
`endif

    reset   = 1'b1;
    estart  = 1'b0;
    ecancel = 1'b0;
    eop     = '0;
    ea      = '0;
    eb      = '0;
    tick();
    tick();
    check("rst_busy", {63'b0, ebusy}, 64'd0);
    check("rst_done", {63'b0, edone}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      issue(tab[i].op, tab[i].a, tab[i].b,
            tab[i].h, tab[i].l, 1'b0);
      wait_done();
      tick();
      check("pulse", {63'b0, edone}, 64'd0);
    end

    for (int i = 0; i < 6; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? 32'd0 : $urandom;
      m  = model(op, a, b);
      issue(op, a, b, m[63:32], m[31:0], 1'b0);
      wait_done();
    end

    // cancel in IDLE wins over estart
    estart  = 1'b1;
    ecancel = 1'b1;
    eop     = 2'b10;
    tick();
    estart  = 1'b0;
    ecancel = 1'b0;
    check("idle_cancel", {63'b0, ebusy}, 64'd0);

    // cancel mid-divide, then reissue
    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    void'(sq.pop_back());
    for (int i = 1; i <= 10; i++) tick();
    ecancel = 1'b1;
    tick();
    ecancel = 1'b0;
    check("cxl_busy", {63'b0, ebusy}, 64'd0);
    check("cxl_done", {63'b0, edone}, 64'd0);
    check("cxl_hilo", {hi, lo}, {last_h, last_l});
    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done();

    // estart held through busy: only reissue at E34 takes
    m = model(2'b00, 32'd12345, 32'd678);
    issue(2'b00, 32'd12345, 32'd678,
          m[63:32], m[31:0], 1'b1);
    wait_done();
    sq.push_back('{m[63:32], m[31:0]});
    tick();
    estart = 1'b0;
    check("reissue", {63'b0, ebusy}, 64'd1);
    wait_done();

    // reset at E20 discards the op
    issue(2'b00, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 19; i++) tick();
    reset = 1'b1;
    tick();
    check("mrst_busy", {63'b0, ebusy}, 64'd0);
    check("mrst_done", {63'b0, edone}, 64'd0);
    check("mrst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    sq.delete();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (edone || ebusy) seen = 1;
    end
    check("mrst_quiet", {63'b0, seen}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
